uart_rx_deserializer: RTL and testbench

- UART receive path, the counterpart of the TX serializer.
- Oversamples the asynchronous serial line `rx_in` at a runtime-selectable prescale.
- Per bit: majority-votes 3 mid-bit samples, checks the start bit for glitches, shifts in DATA_WIDTH data bits LSB-first, then checks optional parity and the stop bit.
- Outputs: parallel word plus a one-cycle `data_valid` pulse and per-frame error flags. Feeds the RX FIFO / register file in the UART subsystem.

---
 rtl/uart_rx_deserializer_if.sv | 25 ++
 rtl/uart_rx_deserializer.sv | 98 +++++++++
 tb/tb_uart_rx_deserializer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: serial line, per-frame config and received-word outputs of the UART receiver
// master: receiver side (rx_in/prescale/par_en/par_typ in; p_data/data_valid/par_err/stp_err/busy out)
// slave:  line driver / consumer side, directions mirrored
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      rx_in;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      par_en;
    logic                      par_typ;
    logic [DATA_WIDTH-1:0]     p_data;
    logic                      data_valid;
    logic                      par_err;
    logic                      stp_err;
    logic                      busy;
    modport master (
        input  rx_in, prescale, par_en, par_typ,
        output p_data, data_valid, par_err, stp_err, busy
    );
    modport slave (
        output rx_in, prescale, par_en, par_typ,
        input  p_data, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampling UART receiver with 3-sample majority vote, start-glitch, parity and stop checks
// clk: system clock (prescale x baud); rst: asynchronous, active-low
// bus (master): rx_in serial line, prescale/par_en/par_typ latched at start detect;
//               p_data last good word, data_valid/par_err/stp_err one-cycle pulses, busy while framing
module uart_rx_deserializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic                    clk,
    input logic                    rst,
    uart_rx_deserializer_if.master bus
);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] p, edge_cnt, half;
    logic [BW-1:0]             bit_cnt;
    logic [DATA_WIDTH-1:0]     shreg;
    logic [2:0]                samp;
    logic                      pen, ptyp, par_bad, armed, last, vote;
    assign half = p >> 1;
    assign last = edge_cnt == p - 1'b1;
    assign vote = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            p              <= '0;
            edge_cnt       <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            samp           <= '0;
            pen            <= 1'b0;
            ptyp           <= 1'b0;
            par_bad        <= 1'b0;
            armed          <= 1'b1;
            bus.p_data     <= '0;
            bus.data_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            bus.stp_err    <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            bus.stp_err    <= 1'b0;
            if (state != IDLE) begin
                edge_cnt <= last ? '0 : edge_cnt + 1'b1;
                if (edge_cnt == half - 1'b1) samp[0] <= bus.rx_in;
                if (edge_cnt == half) samp[1] <= bus.rx_in;
                if (edge_cnt == half + 1'b1) samp[2] <= bus.rx_in;
            end
            case (state)
                IDLE: begin
                    // start detect is cycle 0 of the start bit, so the counter resumes at 1
                    if (!bus.rx_in && armed) begin
                        state    <= START;
                        edge_cnt <= {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
                        p        <= bus.prescale;
                        pen      <= bus.par_en;
                        ptyp     <= bus.par_typ;
                        par_bad  <= 1'b0;
                        bus.busy <= 1'b1;
                    end else begin
                        bus.busy <= 1'b0;
                        armed    <= armed | bus.rx_in;
                    end
                end
                START: if (last) begin
                    state    <= vote ? IDLE : DATA;
                    bus.busy <= !vote;
                end
                DATA: if (last) begin
                    shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt <= '0;
                        state   <= pen ? PARITY : STOP;
                    end
                end
                PARITY: if (last) begin
                    par_bad <= vote != (^shreg ^ ptyp);
                    state   <= STOP;
                end
                STOP: if (last) begin
                    if (vote && !par_bad) begin
                        bus.p_data     <= shreg;
                        bus.data_valid <= 1'b1;
                    end
                    bus.par_err <= par_bad;
                    bus.stp_err <= !vote;
                    // a failed stop bit may be a break; wait for the line to return high
                    armed       <= vote;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed frames with a scoreboard of expected result pulses and their cycles
module tb_uart_rx_deserializer;
    localparam int DW = 8;
    localparam int PW = 6;
    typedef struct {
        logic [2:0]  flags;
        logic [7:0]  data;
        int unsigned at;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned edge_n = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  last_good = 8'h00;
    exp_t        sb[$];
    uart_rx_deserializer_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();
    uart_rx_deserializer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );
    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, got, exp, edge_n);
        end
    endtask
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.data_valid || bus.par_err || bus.stp_err) begin
                if (sb.size() == 0)
                    chk("unexpected_pulse", 32'({bus.data_valid, bus.par_err, bus.stp_err}), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("pulse_flags", 32'({bus.data_valid, bus.par_err, bus.stp_err}), 32'(e.flags));
                    chk("p_data", 32'(bus.p_data), 32'(e.data));
                    chk("pulse_cycle", edge_n, e.at);
                end
            end
        end
    endtask
    task automatic bitd(input logic v, input int p, input bit spike);
        bus.rx_in = v;
        if (spike) begin
            repeat (p / 2) @(negedge clk);
            bus.rx_in = ~v;
            @(negedge clk);
            bus.rx_in = v;
            repeat (p - p / 2 - 1) @(negedge clk);
        end else
            repeat (p) @(negedge clk);
    endtask
    task automatic send(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                        input bit bad_par, input bit bad_stop, input bit spike);
        exp_t e;
        int   n = 2 + DW + (pen ? 1 : 0);
        bit   good = !bad_stop && !(pen && bad_par);
        e.flags = {good, pen && bad_par, bad_stop};
        e.data  = good ? d : last_good;
        e.at    = edge_n + n * p;
        sb.push_back(e);
        if (good) last_good = d;
        bus.prescale = PW'(p);
        bus.par_en   = pen;
        bus.par_typ  = ptyp;
        bus.rx_in    = 1'b0;
        @(negedge clk);
        chk("busy_cycle1", 32'(bus.busy), 32'd1);
        bus.prescale = PW'(p == 8 ? 16 : 8);
        bus.par_en   = ~pen;
        bus.par_typ  = ~ptyp;
        repeat (p - 1) @(negedge clk);
        for (int i = 0; i < DW; i++) bitd(d[i], p, spike);
        if (pen) bitd(^d ^ ptyp ^ bad_par, p, 1'b0);
        bitd(!bad_stop, p, 1'b0);
    endtask
    initial begin
        bus.rx_in    = 1'b1;
        bus.prescale = PW'(8);
        bus.par_en   = 1'b0;
        bus.par_typ  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({bus.p_data, bus.data_valid, bus.par_err, bus.stp_err, bus.busy}), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fork
            monitor();
        join_none
        send(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_last_cycle", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("busy_after_frame", 32'(bus.busy), 32'd0);
        repeat (4) @(negedge clk);
        send(8'hA3, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        send(8'hA3, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        send(8'h6E, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        send(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        chk("break_no_retrigger_50", 32'(bus.busy), 32'd0);
        repeat (50) @(negedge clk);
        chk("break_no_retrigger_100", 32'(bus.busy), 32'd0);
        bus.rx_in = 1'b1;
        @(negedge clk);
        send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        send(8'h5B, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.prescale = PW'(8);
        bus.par_en   = 1'b0;
        bus.rx_in    = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_busy", 32'(bus.busy), 32'd1);
        bus.rx_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_idle", 32'(bus.busy), 32'd0);
        send(8'hC7, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        send(8'h01, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hFE, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.prescale = PW'(16);
        bus.rx_in    = 1'b0;
        repeat (48) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midframe_reset", 32'({bus.p_data, bus.data_valid, bus.par_err, bus.stp_err, bus.busy}), 32'd0);
        last_good = 8'h00;
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.rx_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
